dpram_port_ctrl: RTL and testbench

DPRAM_PORT_CTRL -- requirements
Module: dpram_port_ctrl

---
 rtl/dpram_pkg.sv | 25 ++
 rtl/dpram_rd_pipe.sv | 33 +++
 rtl/dpram_port_ctrl.sv | 124 ++++++++++++
 tb/tb_dpram_port_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared widths, state encoding and helpers for the dual-port RAM port controller,
// its read-return pipe, the RAM model and the benches.
package dpram_pkg;

  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 32;
  localparam int DEPTH        = 32;
  localparam int LEN_W        = 3;
  localparam int RD_LAT       = 2;
  localparam int DRAIN_CYCLES = 2;
  localparam int DRAIN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR    = 2'd1,
    ST_RD    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Burst addresses roll over the top of the array back to word 0.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// Read-return path: delays each issued beat by two cycles and captures the RAM
// output word one cycle after the beat, so data and valid line up.
module dpram_rd_pipe
  import dpram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              beat,
  input  logic [DATA_W-1:0] rd_word,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata
);

  logic [RD_LAT-1:0] vld_reg;
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      vld_reg <= {vld_reg[RD_LAT-2:0], beat};
      // The RAM presents the word for a beat during the following cycle.
      if (vld_reg[0]) begin
        rdata_reg <= rd_word;
      end
    end
  end

  assign rsp_valid = vld_reg[RD_LAT-1];
  assign rsp_rdata = rdata_reg;

endmodule

// File: rtl/dpram_port_ctrl.sv
// Single-port request front end for one port of a synchronous dual-port RAM:
// single-word writes and 1..8 word read bursts with a fixed two-cycle drain.
module dpram_port_ctrl
  import dpram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] I,
  output logic              WEB,
  output logic              CSB,
  output logic              OEB,
  input  logic [DATA_W-1:0] O
);

  state_t              state_reg, state_next;
  logic [LEN_W-1:0]    beat_cnt_reg, beat_cnt_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DRAIN_W-1:0]  drain_cnt_reg, drain_cnt_next;
  logic                beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      beat_cnt_reg  <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      drain_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      beat_cnt_reg  <= beat_cnt_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    beat_cnt_next  = beat_cnt_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    drain_cnt_next = drain_cnt_reg;
    req_ready      = 1'b0;
    CSB            = 1'b1;
    WEB            = 1'b1;
    OEB            = 1'b1;
    beat           = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        // Request fields are captured only here, so changes while busy are ignored.
        if (req_valid) begin
          addr_next = req_addr;
          if (req_we) begin
            wdata_next = req_wdata;
            state_next = ST_WR;
          end else begin
            beat_cnt_next = req_len;
            state_next    = ST_RD;
          end
        end
      end

      ST_WR: begin
        CSB        = 1'b0;
        WEB        = 1'b0;
        state_next = ST_IDLE;
      end

      ST_RD: begin
        CSB  = 1'b0;
        OEB  = 1'b0;
        beat = 1'b1;
        if (beat_cnt_reg == '0) begin
          drain_cnt_next = '0;
          state_next     = ST_DRAIN;
        end else begin
          beat_cnt_next = beat_cnt_reg - LEN_W'(1);
          addr_next     = addr_inc(addr_reg);
        end
      end

      ST_DRAIN: begin
        // Output stays enabled so the last beat's word can still be captured.
        OEB = 1'b0;
        if (drain_cnt_reg == DRAIN_W'(DRAIN_CYCLES - 1)) begin
          state_next = ST_IDLE;
        end else begin
          drain_cnt_next = drain_cnt_reg + DRAIN_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_reg != ST_IDLE);
  assign A    = addr_reg;
  assign I    = wdata_reg;

  dpram_rd_pipe u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .beat      (beat),
    .rd_word   (O),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata)
  );

endmodule

// File: tb/tb_dpram_port_ctrl.sv
// Directed bench for dpram_port_ctrl with a behavioural synchronous RAM on the port
// and a shadow array holding the data each read is expected to return.
module tb_dpram_port_ctrl;
  import dpram_pkg::*;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] I;
  logic              WEB;
  logic              CSB;
  logic              OEB;
  logic [DATA_W-1:0] O;

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] ram_mem [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] exp_mem [DEPTH];

  dpram_port_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .A         (A),
    .I         (I),
    .WEB       (WEB),
    .CSB       (CSB),
    .OEB       (OEB),
    .O         (O)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: write or read commits at the rising edge while selected.
  always @(posedge clk) begin
    if (!CSB) begin
      if (!WEB) ram_mem[A] <= I;
      else      ram_q      <= ram_mem[A];
    end
  end
  assign O = OEB ? '0 : ram_q;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check1({tag, "_ready"}, req_ready, 1'b1);
    check1({tag, "_busy"}, busy, 1'b0);
    check1({tag, "_csb"}, CSB, 1'b1);
    check1({tag, "_web"}, WEB, 1'b1);
    check1({tag, "_oeb"}, OEB, 1'b1);
    check32({tag, "_a"}, 32'(A), 32'h0);
    check32({tag, "_i"}, I, 32'h0);
    check1({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check32({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    $display("[TB] write addr=0x%02h data=0x%08h", addr, data);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
    check1("wr_csb", CSB, 1'b0);
    check1("wr_web", WEB, 1'b0);
    check1("wr_oeb", OEB, 1'b1);
    check32("wr_a", 32'(A), 32'(addr));
    check32("wr_i", I, data);
    check1("wr_ready", req_ready, 1'b0);
    check1("wr_busy", busy, 1'b1);
    exp_mem[addr] = data;
    tick();
    check1("wr_done_ready", req_ready, 1'b1);
    check1("wr_done_csb", CSB, 1'b1);
  endtask

  // Cycle k counts from the accept edge; beats occupy k=1..len+1, drain the next two.
  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len, input bit hold);
    int  n;
    bit  in_rd;
    bit  in_dr;
    bit  exp_v;
    n = int'(len);
    $display("[TB] read addr=0x%02h len=%0d hold=%0d", addr, len, hold);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = addr;
    req_len   = len;
    tick();
    if (!hold) req_valid = 1'b0;
    for (int k = 1; k <= n + 6; k++) begin
      in_rd = (k <= n + 1);
      in_dr = (k == n + 2) || (k == n + 3);
      exp_v = (k >= 3) && (k <= n + 3);
      check1("rd_csb", CSB, !in_rd);
      check1("rd_web", WEB, 1'b1);
      check1("rd_oeb", OEB, !(in_rd || in_dr));
      check1("rd_ready", req_ready, !(in_rd || in_dr));
      check1("rd_busy", busy, in_rd || in_dr);
      if (in_rd) check32("rd_addr", 32'(A), 32'(ADDR_W'(addr + ADDR_W'(k - 1))));
      check1("rsp_valid", rsp_valid, exp_v);
      if (exp_v) check32("rsp_rdata", rsp_rdata, exp_mem[ADDR_W'(addr + ADDR_W'(k - 3))]);
      if (hold) begin
        if (k < n + 4) begin
          req_addr = ADDR_W'($urandom);
          req_len  = LEN_W'($urandom);
        end else begin
          req_valid = 1'b0;
        end
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = '0;
      exp_mem[i] = '0;
    end
    ram_q     = '0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    req_wdata = '0;
    @(negedge clk);
    tick();
    $display("[TB] reset");
    check_reset_state("rst");
    rst = 1'b0;
    tick();

    do_write(5'h0f, 32'h7b);
    do_write(5'h0a, 32'h67);
    tick();
    do_read(5'h0f, 3'd0, 1'b0);
    do_read(5'h0a, 3'd0, 1'b0);

    do_write(5'h1e, 32'hA0);
    do_write(5'h1f, 32'hA1);
    do_write(5'h00, 32'hA2);
    do_write(5'h01, 32'hA3);
    do_read(5'h1e, 3'd3, 1'b0);

    // Read issued on the very first cycle ready returns after the write.
    do_write(5'h03, 32'h55);
    do_read(5'h03, 3'd0, 1'b0);

    do_read(5'h08, 3'd7, 1'b1);

    // Reset during the third beat of an 8-beat burst.
    $display("[TB] read addr=0x10 len=7 with reset on beat 3");
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 5'h10;
    req_len   = 3'd7;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check32("abort_beat3_addr", 32'(A), 32'h12);
    check1("abort_beat3_csb", CSB, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("abort");
    for (int k = 0; k < 8; k++) begin
      check1("abort_no_rsp", rsp_valid, 1'b0);
      check1("abort_no_csb", CSB, 1'b1);
      tick();
    end

    do_read(5'h0a, 3'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
